// File: rtl/ir_encoder_pkg.sv
// ir_encoder_pkg: shared types and constants for the NEC IR transmit encoder.
//   state_e          - frame sequencer states
//   *_UNITS          - segment lengths in NEC units T (562.5 us)
//   BIT_COUNT        - payload bits per frame
//   is_mark()        - true for states that drive a burst
//   seg_units()      - length of the current segment in units
package ir_encoder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark
  } state_e;

  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned BIT0_SPACE_UNITS = 1;
  localparam int unsigned BIT1_SPACE_UNITS = 3;
  localparam int unsigned MARK_UNITS       = 1;

  localparam int unsigned BIT_COUNT = 32;
  localparam int unsigned BIT_IDX_W = $clog2(BIT_COUNT);

  function automatic logic is_mark(state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

  // Idle reports one unit so the derived segment limit never underflows.
  function automatic int unsigned seg_units(state_e s, logic bit_val);
    int unsigned units;
    case (s)
      StLeadMark:  units = LEAD_MARK_UNITS;
      StLeadSpace: units = LEAD_SPACE_UNITS;
      StBitSpace:  units = bit_val ? BIT1_SPACE_UNITS : BIT0_SPACE_UNITS;
      default:     units = MARK_UNITS;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: restartable carrier divider for IR burst modulation.
//   clk     - system clock
//   rst     - synchronous reset, active-low
//   restart - force the count to zero on this edge (start of a mark)
//   carrier - carrier level for the cycle that follows this edge
//             (lookahead, so the consumer can register it alongside its own
//             next-state envelope)
// The count runs 0..CARRIER_DIV-1; the carrier is high for counts
// 0..CARRIER_HIGH-1, so the first cycle after a restart is high.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV  = 658,
  parameter int unsigned CARRIER_HIGH = 219
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);

  localparam int unsigned CntW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == CntW'(CARRIER_DIV - 1))) begin
      cnt_d = '0;
    end
  end

  assign carrier = 32'(cnt_d) < CARRIER_HIGH;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_encoder.sv
// ir_encoder: NEC infrared transmit encoder.
// Accepts a 32-bit frame word on a valid/ready handshake and serialises it as
// leader mark (16T), leader space (8T), 32 pulse-distance bits LSB first
// (1T mark + 1T/3T space) and a 1T stop mark.
//   clk       - system clock
//   rst       - synchronous reset, active-low
//   cmd       - frame word, sent verbatim, latched on accept
//   valid     - cmd is offered
//   ready     - encoder idle, accept happens on valid && ready
//   ir_output - registered LED drive, high = burst
// Build option IR_ENCODER_CARRIER_EN: marks are ANDed with a CARRIER_DIV /
// CARRIER_HIGH carrier restarted at every mark. Without it the raw envelope
// is driven for an external modulator.
module ir_encoder
  import ir_encoder_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 25_000_000,
  parameter int unsigned UNIT_CYCLES  = CLK_HZ * 9 / 16000,
  parameter int unsigned CARRIER_DIV  = 658,
  parameter int unsigned CARRIER_HIGH = 219
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        valid,
  output logic        ready,
  output logic        ir_output
);

  localparam int unsigned MaxSegCycles = LEAD_MARK_UNITS * UNIT_CYCLES;
  localparam int unsigned CntW         = (MaxSegCycles > 1) ? $clog2(MaxSegCycles) : 1;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        dur_q, dur_d;
  logic [CntW-1:0]        seg_last;
  logic                   seg_end;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [31:0]            shift_q, shift_d;
  logic                   ready_q;
  logic                   ir_q;
  logic                   accept;
  logic                   carrier_nxt;

  assign accept = valid && ready_q;

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    // shift_q[0] is always the bit currently being sent.
    seg_last = CntW'(seg_units(state_q, shift_q[0]) * UNIT_CYCLES - 1);
    seg_end  = (dur_q == seg_last);

    if (state_q != StIdle) begin
      dur_d = seg_end ? '0 : dur_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLeadMark;
          dur_d   = '0;
          bit_d   = '0;
          shift_d = cmd;
        end
      end
      StLeadMark: begin
        if (seg_end) state_d = StLeadSpace;
      end
      StLeadSpace: begin
        if (seg_end) state_d = StBitMark;
      end
      StBitMark: begin
        if (seg_end) state_d = StBitSpace;
      end
      StBitSpace: begin
        if (seg_end) begin
          if (bit_q == BIT_IDX_W'(BIT_COUNT - 1)) begin
            state_d = StStopMark;
          end else begin
            state_d = StBitMark;
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StStopMark: begin
        if (seg_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef IR_ENCODER_CARRIER_EN
  logic restart;

  // Every mark is entered from a different state, so a state change into a
  // mark identifies the first cycle of each burst.
  assign restart = is_mark(state_d) && (state_d != state_q);

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .carrier (carrier_nxt)
  );
`else
  logic unused_carrier_cfg;

  assign unused_carrier_cfg = ^{CLK_HZ, CARRIER_DIV, CARRIER_HIGH};
  assign carrier_nxt        = 1'b1;
`endif

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      dur_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= (state_d == StIdle);
      ir_q    <= is_mark(state_d) && carrier_nxt;
    end
  end

  assign ready     = ready_q;
  assign ir_output = ir_q;

endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: self-checking bench for ir_encoder with a shortened unit so
// whole frames fit in a short run. Expected waveforms come from a segment
// list model; frame lengths come from the NEC unit arithmetic.
module tb_ir_encoder;

  localparam int U    = 8;
  localparam int DIV  = 5;
  localparam int HIGH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] cmd = '0;
  logic        ready;
  logic        ir_output;

  always #5 clk = ~clk;

  ir_encoder #(
    .CLK_HZ       (25_000_000),
    .UNIT_CYCLES  (U),
    .CARRIER_DIV  (DIV),
    .CARRIER_HIGH (HIGH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .valid     (valid),
    .ready     (ready),
    .ir_output (ir_output)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit wave_q[$];

  typedef struct {
    logic [31:0] cmd;
    int          units;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Expected LED level, one entry per clock, for a segment of 'units' T.
  task automatic push_seg(input bit mark, input int units);
    bit lvl;
    for (int i = 0; i < units * U; i++) begin
      lvl = mark;
`ifdef IR_ENCODER_CARRIER_EN
      if (mark) lvl = (i % DIV) < HIGH;
`endif
      exp_q.push_back(lvl);
    end
  endtask

  task automatic build_model(input logic [31:0] c);
    exp_q.delete();
    push_seg(1'b1, 16);
    push_seg(1'b0, 8);
    for (int b = 0; b < 32; b++) begin
      push_seg(1'b1, 1);
      push_seg(1'b0, c[b] ? 3 : 1);
    end
    push_seg(1'b1, 1);
  endtask

  // Starts one cycle after accept; records until ready comes back.
  task automatic capture(input bit disturb);
    int n = 0;
    wave_q.delete();
    while (1) begin
      wave_q.push_back(ir_output);
      n++;
      if (disturb) begin
        valid = 1'($urandom);
        cmd   = $urandom;
      end
      @(posedge clk);
      #1;
      if (ready) break;
      if (n > 200 * U) begin
        note_fail("capture_timeout");
        break;
      end
    end
    if (disturb) valid = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!ready) note_fail("wait_ready");
  endtask

  task automatic start_frame(input logic [31:0] c, input bit hold_valid);
    wait_ready();
    cmd   = c;
    valid = 1'b1;
    @(posedge clk);
    #1;
    check("accept_ready_low", int'(ready), 0);
    check("accept_leader_high", int'(ir_output), 1);
    if (!hold_valid) valid = 1'b0;
  endtask

  task automatic compare_wave(input string name);
    int n   = (wave_q.size() < exp_q.size()) ? wave_q.size() : exp_q.size();
    int idx = -1;
    for (int i = 0; i < n; i++) begin
      if (idx < 0 && wave_q[i] != exp_q[i]) idx = i;
    end
    if (idx < 0 && wave_q.size() != exp_q.size()) idx = n;
    n_checks++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL %s: first difference at cycle %0d, length got %0d expected %0d",
               name, idx, wave_q.size(), exp_q.size());
    end
  endtask

`ifndef IR_ENCODER_CARRIER_EN
  // Receiver-style decode of the unmodulated envelope from run lengths.
  task automatic decode(output logic [31:0] bits, output bit ok);
    int lens[$];
    bit lv[$];
    int run = 0;
    for (int i = 0; i < wave_q.size(); i++) begin
      run++;
      if (i == wave_q.size() - 1 || wave_q[i+1] != wave_q[i]) begin
        lens.push_back(run);
        lv.push_back(wave_q[i]);
        run = 0;
      end
    end
    bits = '0;
    ok   = (lens.size() == 67);
    if (ok) begin
      ok = lv[0] && lens[0] == 16 * U && !lv[1] && lens[1] == 8 * U;
      for (int b = 0; b < 32; b++) begin
        if (!lv[2+2*b] || lens[2+2*b] != U) ok = 1'b0;
        if (lens[3+2*b] == 3 * U) bits[b] = 1'b1;
        else if (lens[3+2*b] != U) ok = 1'b0;
      end
      if (!lv[66] || lens[66] != U) ok = 1'b0;
    end
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    logic [31:0] c, c2, bits;
    bit          ok;
    int          highs;

    tbl[0] = '{32'hFB040707, 117};
    tbl[1] = '{32'h00000000, 89};
    tbl[2] = '{32'hFFFFFFFF, 153};
    tbl[3] = '{32'h00000001, 91};
    tbl[4] = '{32'h80000000, 91};

    // Reset held with valid high: nothing may start.
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_ir", int'(ir_output), 0);
      check("reset_ready", int'(ready), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("release_ready", int'(ready), 1);
    check("release_ir", int'(ir_output), 0);
    valid = 1'b0;

    foreach (tbl[t]) begin
      start_frame(tbl[t].cmd, 1'b0);
      capture(1'b0);
      check("frame_len", wave_q.size(), tbl[t].units * U);
      check("frame_end_low", int'(ir_output), 0);
      build_model(tbl[t].cmd);
      compare_wave("frame_wave");
`ifndef IR_ENCODER_CARRIER_EN
      decode(bits, ok);
      check("decode_ok", int'(ok), 1);
      check("decode_bits", int'(bits), int'(tbl[t].cmd));
`endif
    end

    // Busy protection: valid and cmd thrash for the whole frame.
    c = 32'hA5C30F1E;
    start_frame(c, 1'b0);
    capture(1'b1);
    build_model(c);
    compare_wave("busy_wave");
    repeat (4) @(posedge clk);
    #1;
    check("busy_no_restart", int'(ready), 1);

    // Back-to-back: valid held, second word offered mid-frame.
    c  = $urandom;
    c2 = $urandom;
    start_frame(c, 1'b1);
    cmd = c2;
    capture(1'b0);
    build_model(c);
    compare_wave("b2b_first_wave");
    check("b2b_gap_low", int'(ir_output), 0);
    @(posedge clk);
    #1;
    check("b2b_accept_ready", int'(ready), 0);
    check("b2b_accept_ir", int'(ir_output), 1);
    valid = 1'b0;
    capture(1'b0);
    build_model(c2);
    compare_wave("b2b_second_wave");

    // Reset during bit 10's mark of an all-zero frame.
    start_frame(32'h0, 1'b0);
    repeat (44 * U + 2) @(posedge clk);
    #1;
    check("pre_reset_mark", int'(ir_output), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ir", int'(ir_output), 0);
    check("midreset_ready", int'(ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_release_ready", int'(ready), 1);
    highs = 0;
    repeat (40 * U) begin
      @(posedge clk);
      #1;
      if (ir_output) highs++;
    end
    check("midreset_no_resume", highs, 0);
    c = 32'h3C3C00FF;
    start_frame(c, 1'b0);
    capture(1'b0);
    build_model(c);
    compare_wave("post_reset_wave");

    // Random words against unit arithmetic and the segment model.
    for (int r = 0; r < 12; r++) begin
      c = $urandom;
      start_frame(c, 1'b0);
      capture(1'b0);
      check("rand_len", wave_q.size(),
            (24 + 4 * $countones(c) + 2 * (32 - $countones(c)) + 1) * U);
      build_model(c);
      compare_wave("rand_wave");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
